xbus_interconnect: RTL and testbench

- Parametrised, registered successor to the fixed 4-slave xbus decode/read-mux: one xbus master (core) to NSLAVES slaves.
- Adds wait-state support (per-slave ready), a per-access timeout, decode-miss error responses and error capture registers.
- Sits between core and the ROM/RAM/peripheral slaves at SoC top level.

---
 rtl/xbus_interconnect_if.sv | 25 ++
 rtl/xbus_interconnect.sv | 133 +++++++++++++
 tb/tb_xbus_interconnect.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/xbus_interconnect_if.sv
// Core-side xbus: master drives the access strobe and request fields,
// the interconnect returns a registered response qualified by m_rdy.
interface xbus_interconnect_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  m_as;
  logic                  m_we;
  logic [DATA_W/8-1:0]   m_be;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W-1:0]     m_rdata;
  logic                  m_rdy;
  logic                  m_err;

  modport master (
    output m_as, m_we, m_be, m_addr, m_wdata,
    input  m_rdata, m_rdy, m_err
  );

  modport slave (
    input  m_as, m_we, m_be, m_addr, m_wdata,
    output m_rdata, m_rdy, m_err
  );
endinterface

// File: rtl/xbus_interconnect.sv
// One xbus master to NSLAVES address-decoded slaves with wait states, timeout and error capture.
// Latency: m_rdy two cycles after m_as is sampled for a zero-wait slave, +1 per wait cycle; decode miss one cycle.
// Backpressure: per-slave s_rdy stretches ACCESS; the master holds m_as until the one-cycle m_rdy pulse.
module xbus_interconnect #(
  parameter int                          NSLAVES  = 4,
  parameter int                          ADDR_W   = 32,
  parameter int                          DATA_W   = 32,
  parameter logic [NSLAVES*ADDR_W-1:0]   SLV_BASE = {32'h0003_0000, 32'h0002_0000,
                                                     32'h0001_0000, 32'h0000_0000},
  parameter logic [NSLAVES*ADDR_W-1:0]   SLV_MASK = {4{32'hFFFF_0000}},
  parameter int                          TIMEOUT  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  xbus_interconnect_if.slave           m,
  output logic [NSLAVES-1:0]           s_cs,
  output logic                         s_we,
  output logic [DATA_W/8-1:0]          s_be,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NSLAVES*DATA_W-1:0]    s_rdata,
  input  logic [NSLAVES-1:0]           s_rdy,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [15:0]                  err_cnt
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic [NSLAVES-1:0]  sel, hit_sel;
  logic                hit, sel_rdy, timeout;
  logic [DATA_W-1:0]   sel_rdata;
  logic [CNT_W-1:0]    wait_cnt;
  logic [15:0]         err_cnt_inc;

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((m.m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit        = 1'b1;
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdy   = |(s_rdy & sel);
    sel_rdata = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (sel[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign timeout     = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign err_cnt_inc = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
  assign s_cs        = (state == ACCESS) ? sel : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m.m_as) state_nxt = hit ? ACCESS : RESP;
      ACCESS:  if (sel_rdy || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel       <= '0;
      s_we      <= 1'b0;
      s_be      <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      m.m_rdata <= '0;
      m.m_rdy   <= 1'b0;
      m.m_err   <= 1'b0;
      err_addr  <= '0;
      err_cnt   <= '0;
      wait_cnt  <= '0;
    end else begin
      m.m_rdy <= 1'b0;
      m.m_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m.m_as) begin
            s_we    <= m.m_we;
            s_be    <= m.m_be;
            s_addr  <= m.m_addr;
            s_wdata <= m.m_wdata;
            sel     <= hit_sel;
            if (!hit) begin
              m.m_rdata <= '0;
              m.m_rdy   <= 1'b1;
              m.m_err   <= 1'b1;
              err_addr  <= m.m_addr;
              err_cnt   <= err_cnt_inc;
            end
          end
        end
        ACCESS: begin
          // A ready in the final allowed cycle still completes cleanly.
          if (sel_rdy) begin
            m.m_rdata <= s_we ? '0 : sel_rdata;
            m.m_rdy   <= 1'b1;
            wait_cnt  <= '0;
          end else if (timeout) begin
            m.m_rdata <= '0;
            m.m_rdy   <= 1'b1;
            m.m_err   <= 1'b1;
            err_addr  <= s_addr;
            err_cnt   <= err_cnt_inc;
            wait_cnt  <= '0;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_interconnect.sv
// Randomized bench for xbus_interconnect against a transaction-level reference model.
module tb_xbus_interconnect;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  // Slave 1 widened to 0x0000_0000..0x0001_FFFF so it overlaps slave 0.
  localparam logic [NS*AW-1:0] BASE = {32'h0003_0000, 32'h0002_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFF_0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xbus_interconnect_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [NS-1:0]    s_cs;
  logic             s_we;
  logic [DW/8-1:0]  s_be;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_rdy;
  logic [AW-1:0]    err_addr;
  logic [15:0]      err_cnt;
  logic [DW-1:0]    sdat [NS];

  assign s_rdata = {sdat[3], sdat[2], sdat[1], sdat[0]};

  xbus_interconnect #(
    .NSLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .m(bus),
    .s_cs(s_cs), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_rdy(s_rdy), .err_addr(err_addr), .err_cnt(err_cnt)
  );

  // Reference address map, written out per slave in index order.
  logic [31:0] mbase [NS] = '{32'h0000_0000, 32'h0000_0000, 32'h0002_0000, 32'h0003_0000};
  logic [31:0] mmask [NS] = '{32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned mdl_cnt = 0;
  logic [31:0] mdl_eaddr = '0;
  logic [31:0] mdl_last = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mmask[i]) == mbase[i]) return i;
    return -1;
  endfunction

  // One full transaction; called just after a falling edge with the DUT idle.
  task automatic do_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic [31:0] rdv);
    int          idx, resp_j;
    logic [NS-1:0] exp_cs;
    logic        exp_err;
    logic [31:0] exp_rdata;
    idx    = decode(addr);
    exp_cs = '0;
    for (int k = 0; k < NS; k++) sdat[k] = $urandom;
    if (idx >= 0) begin
      exp_cs[idx] = 1'b1;
      sdat[idx]   = rdv;
    end
    if (idx < 0) begin
      resp_j = 1; exp_err = 1'b1;
    end else if (waits < TO) begin
      resp_j = waits + 2; exp_err = 1'b0;
    end else begin
      resp_j = TO + 1; exp_err = 1'b1;
    end
    exp_rdata = (!exp_err && !we) ? sdat[idx] : 32'h0;
    if (exp_err) begin
      mdl_eaddr = addr;
      if (mdl_cnt != 32'hFFFF) mdl_cnt++;
    end
    bus.m_as = 1'b1; bus.m_we = we; bus.m_be = be; bus.m_addr = addr; bus.m_wdata = wdata;
    for (int j = 1; j <= resp_j; j++) begin
      @(posedge clk); #1;
      s_rdy = NS'($urandom);
      if (idx >= 0) s_rdy[idx] = (j - 1 >= waits);
      @(negedge clk);
      if (j < resp_j) begin
        check("wait_rdy", bus.m_rdy, 0);
        check("wait_cs", s_cs, exp_cs);
        check("s_addr", s_addr, addr);
        check("s_wdata", s_wdata, wdata);
        check("s_we", s_we, we);
        check("s_be", s_be, be);
      end else begin
        check("resp_rdy", bus.m_rdy, 1);
        check("resp_err", bus.m_err, exp_err);
        check("resp_rdata", bus.m_rdata, exp_rdata);
        check("resp_cs", s_cs, 0);
        check("err_cnt", err_cnt, mdl_cnt);
        check("err_addr", err_addr, mdl_eaddr);
      end
    end
    bus.m_as = 1'b0;
    mdl_last = exp_rdata;
    @(negedge clk);
    check("idle_rdy", bus.m_rdy, 0);
    check("idle_err", bus.m_err, 0);
    check("hold_rdata", bus.m_rdata, mdl_last);
    check("idle_cs", s_cs, 0);
  endtask

  initial begin
    int r, w;
    logic [31:0] a;
    rst = 1'b0;
    bus.m_as = 1'b0; bus.m_we = 1'b0; bus.m_be = '0; bus.m_addr = '0; bus.m_wdata = '0;
    s_rdy = '0;
    for (int k = 0; k < NS; k++) sdat[k] = '0;
    #12;
    check("rst_cs", s_cs, 0);
    check("rst_rdy", bus.m_rdy, 0);
    check("rst_err", bus.m_err, 0);
    check("rst_rdata", bus.m_rdata, 0);
    check("rst_s_req", {s_we, s_be, s_addr, s_wdata}, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_access(1'b0, 4'hF, 32'h0000_1000, 32'h0, 0, 32'hDEADBEEF);   // zero-wait read, slave 0
    do_access(1'b1, 4'hF, 32'h0001_0004, 32'h1234_5678, 3, 32'h0);  // write with 3 wait cycles
    do_access(1'b0, 4'hF, 32'h0002_0000, 32'h0, 1000, 32'h0);       // stuck slave -> timeout
    do_access(1'b0, 4'hF, 32'h8000_0000, 32'h0, 0, 32'h0);          // decode miss
    do_access(1'b0, 4'h3, 32'h0000_0000, 32'h0, 1, 32'hA5A5_0001);  // overlap -> slave 0
    do_access(1'b0, 4'hC, 32'h0001_8000, 32'h0, 2, 32'h0BAD_F00D);  // slave 1 only
    do_access(1'b0, 4'hF, 32'h0003_0010, 32'h0, TO - 1, 32'hC0DE_0003); // ready at timeout edge
    do_access(1'b1, 4'h1, 32'h0003_0020, 32'h55, TO, 32'h0);        // one cycle too slow

    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 5);
      if (r < 4)       a = {16'(r), 16'($urandom)};
      else if (r == 4) a = {16'h0000, 16'($urandom)};
      else             a = {1'b1, 31'($urandom)};
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 3);
      do_access(1'($urandom), 4'($urandom), a, $urandom, w, $urandom);
    end

    // Reset in the middle of a waiting access.
    bus.m_as = 1'b1; bus.m_we = 1'b0; bus.m_be = 4'hF; bus.m_addr = 32'h0002_0000;
    s_rdy = '0;
    repeat (3) @(posedge clk);
    #3;
    check("mid_cs", s_cs, 4'b0100);
    rst = 1'b0;
    #1;
    check("arst_cs", s_cs, 0);
    check("arst_rdy", bus.m_rdy, 0);
    check("arst_err_cnt", err_cnt, 0);
    check("arst_err_addr", err_addr, 0);
    check("arst_rdata", bus.m_rdata, 0);
    mdl_cnt = 0; mdl_eaddr = '0; mdl_last = '0;
    bus.m_as = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", bus.m_rdy, 0);
    do_access(1'b0, 4'hF, 32'h0002_0040, 32'h0, 1, 32'h7777_8888);
    do_access(1'b0, 4'hF, 32'h4000_0000, 32'h0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
